// File: rtl/vram_px_arbiter_if.sv
// Signal bundle between the pixel-plane VRAM arbiter, the PixelEngine, the CPU bus
// and the VRAM macro.
interface vram_px_arbiter_if #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              blank;
  logic              gpu_req;
  logic [ADDR_W-1:0] gpu_addr;
  logic [DATA_W-1:0] gpu_q;
  logic              cpu_start;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_busy;
  logic [LW-1:0]     fifo_level;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  // CPU handshake: cpu_start is a one-cycle strobe honoured only while cpu_busy is low;
  // every honoured strobe yields exactly one cpu_done pulse, with cpu_q valid alongside it for reads.
  modport master (
    output blank, gpu_req, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    input  gpu_q, cpu_done, cpu_q, cpu_busy, fifo_level, ram_addr, ram_d, ram_we
  );

  modport slave (
    input  blank, gpu_req, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data, ram_q,
    output gpu_q, cpu_done, cpu_q, cpu_busy, fifo_level, ram_addr, ram_d, ram_we
  );
endinterface

// File: rtl/vram_px_arbiter.sv
// Single-port VRAM arbiter: PixelEngine reads own every slot they ask for; CPU writes
// are buffered and retired in idle slots, CPU reads wait behind all buffered writes.
module vram_px_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  vram_px_arbiter_if.slave        bus,
  output logic [1:0]              dbg_rd_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_WAIT    = 2'd1,
    R_ISSUE   = 2'd2,
    R_CAPTURE = 2'd3
  } rd_state_e;

  rd_state_e                rd_state_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [DATA_W-1:0]        cpu_q_q;
  logic                     wr_pend_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [DATA_W-1:0]        wr_data_q;
  logic [ADDR_W+DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [LW-1:0]            level_q;

  logic              gpu_slot;
  logic              busy;
  logic              accept;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign gpu_slot   = bus.gpu_req & ~bus.blank;
  assign busy       = wr_pend_q | (rd_state_q != R_IDLE);
  assign accept     = bus.cpu_start & ~busy;
  assign fifo_empty = (level_q == '0);
  // Fullness is judged on the pre-pop level, so a full FIFO frees space one cycle after a pop.
  assign push       = wr_pend_q & (level_q != FULL_LVL);
  assign pop        = ~gpu_slot & (rd_state_q != R_ISSUE) & ~fifo_empty;
  assign {head_addr, head_data} = fifo_mem_q[rd_ptr_q];

  always_comb begin
    bus.ram_addr = bus.gpu_addr;
    bus.ram_d    = head_data;
    bus.ram_we   = 1'b0;
    if (!gpu_slot) begin
      if (rd_state_q == R_ISSUE) begin
        bus.ram_addr = rd_addr_q;
      end else if (!fifo_empty) begin
        bus.ram_addr = head_addr;
        bus.ram_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {wr_addr_q, wr_data_q};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (accept && bus.cpu_we) begin
      wr_pend_q <= 1'b1;
      wr_addr_q <= bus.cpu_addr;
      wr_data_q <= bus.cpu_data;
    end else if (push) begin
      wr_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      cpu_q_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (accept && !bus.cpu_we) begin
            rd_addr_q  <= bus.cpu_addr;
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT:    if (fifo_empty) rd_state_q <= R_ISSUE;
        R_ISSUE:   if (!gpu_slot)  rd_state_q <= R_CAPTURE;
        R_CAPTURE: begin
          cpu_q_q    <= bus.ram_q;
          rd_state_q <= R_IDLE;
        end
        default:   rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Read data is forwarded straight from the macro in the capture cycle so it lines up with cpu_done.
  assign bus.cpu_q      = (rd_state_q == R_CAPTURE) ? bus.ram_q : cpu_q_q;
  assign bus.cpu_done   = push | (rd_state_q == R_CAPTURE);
  assign bus.cpu_busy   = busy;
  assign bus.gpu_q      = bus.ram_q;
  assign bus.fifo_level = level_q;
  assign dbg_rd_state_o = rd_state_q;
endmodule

// File: tb/tb_vram_px_arbiter.sv
// Bench for vram_px_arbiter: VRAM macro model, CPU-visible memory model, retire-order queue.
module tb_vram_px_arbiter;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int MEM_SIZE   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [1:0] dbg_rd_state;

  vram_px_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  vram_px_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .bus            (bus),
    .dbg_rd_state_o (dbg_rd_state)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]        ram_m   [MEM_SIZE];
  logic [DATA_W-1:0]        ref_mem [MEM_SIZE];
  logic [DATA_W-1:0]        ram_q_m = '0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int gpu_mode = 0;

  assign bus.ram_q = ram_q_m;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // VRAM macro: synchronous read, one-cycle latency
  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ram_m[i] = pattern(ADDR_W'(i));
    forever begin
      @(posedge clk);
      ram_q_m <= ram_m[bus.ram_addr];
      if (bus.ram_we === 1'b1) ram_m[bus.ram_addr] <= bus.ram_d;
    end
  end

  // PixelEngine stimulus: 0 idle, 1 always requesting, 2 toggling, 3 random, other: requesting in blank
  initial begin
    bit tgl;
    tgl = 1'b0;
    bus.gpu_req  = 1'b0;
    bus.blank    = 1'b0;
    bus.gpu_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      tgl = ~tgl;
      bus.gpu_addr = ADDR_W'($urandom);
      case (gpu_mode)
        0: begin bus.gpu_req = 1'b0; bus.blank = 1'b0; end
        1: begin bus.gpu_req = 1'b1; bus.blank = 1'b0; end
        2: begin bus.gpu_req = tgl;  bus.blank = 1'b0; end
        3: begin
          bus.gpu_req = 1'($urandom_range(0, 1));
          bus.blank   = ($urandom_range(0, 3) == 0);
        end
        default: begin bus.gpu_req = 1'b1; bus.blank = 1'b1; end
      endcase
    end
  end

  // Scoreboard: PixelEngine priority, gpu_q pass-through, in-order write retirement
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.gpu_req === 1'b1 && bus.blank === 1'b0) begin
        total++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== bus.gpu_addr) begin
          bad++;
          $display("FAIL gpu_priority ram_we=%b ram_addr=%h expected we=0 addr=%h", bus.ram_we, bus.ram_addr, bus.gpu_addr);
        end
      end
      total++;
      if (bus.gpu_q !== ram_q_m) begin
        bad++;
        $display("FAIL gpu_q got=%h expected=%h", bus.gpu_q, ram_q_m);
      end
      if (bus.ram_we === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h expected no write", bus.ram_addr, bus.ram_d);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          if ({bus.ram_addr, bus.ram_d} !== e) begin
            bad++;
            $display("FAIL retire_order got=%h/%h expected=%h/%h", bus.ram_addr, bus.ram_d, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction; lat counts cycles from the start strobe to cpu_done
  task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      output int lat, output logic [DATA_W-1:0] q);
    bit got;
    got = 1'b0;
    lat = -1;
    q   = '0;
    step();
    bus.cpu_start = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    @(negedge clk);
    total++;
    if (bus.cpu_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_at_start busy=%b expected 0", bus.cpu_busy);
    end
    if (we) begin
      exp_q.push_back({a, d});
      ref_mem[a] = d;
    end
    step();
    bus.cpu_start = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1) begin
        got = 1'b1;
        lat = i;
        q   = bus.cpu_q;
      end else begin
        step();
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout addr=%h no cpu_done within 200 cycles", a);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      @(negedge clk);
      if (bus.fifo_level == 0 && bus.cpu_busy == 1'b0) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout level=%0d expected 0", bus.fifo_level);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL retire_missing outstanding=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.fifo_level !== '0) begin bad++; $display("FAIL rst_level got=%0d expected 0", bus.fifo_level); end
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b expected 0", bus.cpu_busy); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b expected 0", bus.cpu_done); end
    total++; if (bus.cpu_q !== '0) begin bad++; $display("FAIL rst_cpu_q got=%h expected 0", bus.cpu_q); end
    total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b expected 0", bus.ram_we); end
    step();
    nreset = 1'b1;
  endtask

  task automatic test_write_full();
    int lat;
    logic [DATA_W-1:0] q;
    gpu_mode = 1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, ADDR_W'(32'h00100 + i), DATA_W'($urandom), lat, q);
      total++; if (lat != 1) begin bad++; $display("FAIL full_wr_lat%0d got=%0d expected 1", i, lat); end
      total++; if (bus.fifo_level !== LW'(i)) begin bad++; $display("FAIL full_level%0d got=%0d expected %0d", i, bus.fifo_level, i); end
      total++; if (bus.cpu_busy !== 1'b1) begin bad++; $display("FAIL full_busy%0d got=%b expected 1", i, bus.cpu_busy); end
    end
    step();
    @(negedge clk);
    total++; if (bus.fifo_level !== LW'(4)) begin bad++; $display("FAIL full_level_4 got=%0d expected 4", bus.fifo_level); end
    step();
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00104; bus.cpu_data = 8'hE7;
    exp_q.push_back({17'h00104, 8'hE7});
    ref_mem[17'h00104] = 8'hE7;
    @(negedge clk);
    step();
    bus.cpu_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL full_stall_done c=%0d got=%b expected 0", c, bus.cpu_done); end
      total++; if (bus.fifo_level !== LW'(4)) begin bad++; $display("FAIL full_stall_level got=%0d expected 4", bus.fifo_level); end
      if (c < 3) step();
    end
    gpu_mode = 5;
    step();
    @(negedge clk);
    total++; if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL blank_pop got=%b expected 1", bus.ram_we); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL blank_early_done got=%b expected 0", bus.cpu_done); end
    step();
    @(negedge clk);
    total++; if (bus.cpu_done !== 1'b1) begin bad++; $display("FAIL blank_done got=%b expected 1", bus.cpu_done); end
    drain();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [DATA_W-1:0] q;
    gpu_mode = 1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, ADDR_W'(32'h10000 + i), DATA_W'($urandom), lat, q);
      total++; if (lat != 1) begin bad++; $display("FAIL rmw_lat%0d got=%0d expected 1", i, lat); end
    end
    step();
    total++; if (bus.fifo_level !== LW'(3)) begin bad++; $display("FAIL rmw_level3 got=%0d expected 3", bus.fifo_level); end
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'h10003; bus.cpu_data = 8'h99;
    #3;
    nreset = 1'b0;
    #1;
    total++; if (bus.fifo_level !== '0) begin bad++; $display("FAIL rmw_level got=%0d expected 0", bus.fifo_level); end
    total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rmw_ram_we got=%b expected 0", bus.ram_we); end
    total++; if (bus.cpu_busy !== 1'b0) begin bad++; $display("FAIL rmw_busy got=%b expected 0", bus.cpu_busy); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL rmw_done got=%b expected 0", bus.cpu_done); end
    bus.cpu_start = 1'b0;
    exp_q.delete();
    gpu_mode = 0;
    step();
    nreset = 1'b1;
    send(1'b1, 17'h000A0, 8'h3C, lat, q);
    total++; if (lat != 1) begin bad++; $display("FAIL post_rst_lat got=%0d expected 1", lat); end
    step();
    @(negedge clk);
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 17'h000A0 || bus.ram_d !== 8'h3C) begin
      bad++;
      $display("FAIL post_rst_retire we=%b addr=%h d=%h expected 1/000a0/3c", bus.ram_we, bus.ram_addr, bus.ram_d);
    end
    drain();
  endtask

  task automatic test_write_then_read();
    int lat;
    logic [DATA_W-1:0] q;
    gpu_mode = 2;
    send(1'b1, 17'h01234, 8'hAB, lat, q);
    send(1'b0, 17'h01234, 8'h00, lat, q);
    total++; if (q !== ref_mem[17'h01234]) begin bad++; $display("FAIL wr_rd_data got=%h expected %h", q, ref_mem[17'h01234]); end
    total++; if (lat < 3) begin bad++; $display("FAIL wr_rd_lat got=%0d expected >=3", lat); end
    drain();
  endtask

  task automatic test_toggle_writes();
    int lat;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] d_arr [8];
    gpu_mode = 2;
    for (int i = 0; i < 8; i++) begin
      d_arr[i] = DATA_W'($urandom);
      send(1'b1, ADDR_W'(i), d_arr[i], lat, q);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram_m[i] !== d_arr[i]) begin bad++; $display("FAIL toggle_mem%0d got=%h expected %h", i, ram_m[i], d_arr[i]); end
    end
  endtask

  task automatic test_read_latency();
    int lat;
    logic [DATA_W-1:0] q;
    gpu_mode = 0;
    send(1'b0, 17'h1FFFF, 8'h00, lat, q);
    total++; if (lat != 3) begin bad++; $display("FAIL rd_lat got=%0d expected 3", lat); end
    total++; if (q !== 8'h5C) begin bad++; $display("FAIL rd_data got=%h expected 5c", q); end
    step();
    @(negedge clk);
    total++; if (bus.cpu_q !== 8'h5C) begin bad++; $display("FAIL rd_hold got=%h expected 5c", bus.cpu_q); end
    total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL rd_done_pulse got=%b expected 0", bus.cpu_done); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int dones;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] rq;
    dones = 0;
    rq = '0;
    gpu_mode = 1;
    step();
    bus.cpu_start = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'h000A0;
    @(negedge clk);
    step();
    bus.cpu_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1) dones++;
      step();
      bus.cpu_start = 1'b1;
      bus.cpu_we    = c[0];
      bus.cpu_addr  = ADDR_W'(32'h000B0 + c);
      bus.cpu_data  = DATA_W'($urandom);
    end
    @(negedge clk);
    if (bus.cpu_done === 1'b1) dones++;
    gpu_mode = 0;
    step();
    bus.cpu_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1) begin dones++; rq = bus.cpu_q; end
      step();
    end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_ignore_dones got=%0d expected 1", dones); end
    total++; if (rq !== ref_mem[17'h000A0]) begin bad++; $display("FAIL busy_ignore_data got=%h expected %h", rq, ref_mem[17'h000A0]); end
    gpu_mode = 3;
    for (int i = 0; i < 10; i++) send(1'b1, ADDR_W'(32'h00200 + i), DATA_W'($urandom), lat, q);
    drain();
    for (int i = 0; i < 10; i += 4) begin
      send(1'b0, ADDR_W'(32'h00200 + i), 8'h00, lat, q);
      total++;
      if (q !== ref_mem[32'h00200 + i]) begin bad++; $display("FAIL wrap_rd%0d got=%h expected %h", i, q, ref_mem[32'h00200 + i]); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    gpu_mode = 3;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = ADDR_W'(32'h00300 + $urandom_range(0, 15));
      send(we, a, DATA_W'($urandom), lat, q);
      if (!we) begin
        total++;
        if (q !== ref_mem[a]) begin bad++; $display("FAIL rand_rd addr=%h got=%h expected %h", a, q, ref_mem[a]); end
        total++;
        if (lat < 3) begin bad++; $display("FAIL rand_rd_lat addr=%h got=%0d expected >=3", a, lat); end
      end
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pattern(ADDR_W'(i));
    bus.cpu_start = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    test_reset();
    test_write_full();
    test_reset_mid_write();
    test_write_then_read();
    test_toggle_writes();
    test_read_latency();
    test_busy_ignore();
    test_random();
    gpu_mode = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_px_arbiter.md
# vram_px_arbiter

Shares the single port of the pixel-plane VRAM (VRAMpixel, 8-bit × 128K) between the PixelEngine read stream and CPU bus read/write transactions. The PixelEngine has absolute priority; CPU writes are buffered in a small FIFO and retired only in cycles the PixelEngine does not use, and CPU reads are ordered behind all buffered writes. Sits between the CPU memory-mapped VRAM interface, the PixelEngine `vram_addr`/`vram_q` pair, and the VRAM macro, in the `clkMuxOut` domain.

## Interface
- ADDR_W, 17, VRAM address width
- DATA_W, 8, VRAM data width
- FIFO_DEPTH, 4, CPU write buffer entries (power of two, ≥2)

- clk  in  1  pixel/render clock (`clkMuxOut`)
- nreset  in  1  asynchronous, active-low reset
- blank  in  1  selected blanking signal; 1 = PixelEngine slot free regardless of gpu_req
- gpu_req  in  1  PixelEngine read request this cycle
- gpu_addr  in  ADDR_W  PixelEngine read address
- gpu_q  out  DATA_W  read data to PixelEngine, = ram_q (combinational)
- cpu_start  in  1  one-cycle transaction strobe
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_start
- cpu_addr  in  ADDR_W  sampled with cpu_start
- cpu_data  in  DATA_W  write data, sampled with cpu_start
- cpu_done  out  1  one-cycle completion pulse
- cpu_q  out  DATA_W  read data, valid with cpu_done on reads, held until next read completes
- cpu_busy  out  1  transaction outstanding; cpu_start ignored while 1
- fifo_level  out  $clog2(FIFO_DEPTH)+1  write FIFO occupancy
- ram_addr  out  ADDR_W  VRAM address
- ram_d  out  DATA_W  VRAM write data
- ram_we  out  1  VRAM write enable
- ram_q  in  DATA_W  VRAM read data, 1-cycle synchronous latency

## Operation
- Slot owner per cycle (combinational): gpu_slot = gpu_req & ~blank. If gpu_slot: ram_addr=gpu_addr, ram_we=0. Else if read issue pending (state R_ISSUE): ram_addr=read addr, ram_we=0. Else if FIFO non-empty: ram_addr/ram_d = FIFO head, ram_we=1, pop. Else ram_addr=gpu_addr, ram_we=0.
- Write path: cpu_start & cpu_we latches addr/data into pending register, cpu_busy=1. Each cycle with pending write and fifo_level<FIFO_DEPTH (pre-pop value): push, cpu_done=1 next cycle, cpu_busy falls with done. Full FIFO holds pending write until a pop frees space.
- Read FSM: R_IDLE → (cpu_start & ~cpu_we) → R_WAIT; R_WAIT → R_ISSUE when fifo_level==0; R_ISSUE holds until cycle with ~gpu_slot, address driven that cycle → R_CAPTURE; R_CAPTURE registers ram_q into cpu_q, asserts cpu_done → R_IDLE. Reads never overtake buffered writes; pending-write and read are exclusive (single outstanding transaction).
- FIFO: circular, ADDR_W+DATA_W wide, pointers wrap modulo FIFO_DEPTH; push and pop in same cycle leave level unchanged.
- cpu_start while cpu_busy: ignored, no done, no state change.

## Timing
- Reset (nreset low, async): FIFO empty, fifo_level=0, FSM R_IDLE, pending cleared, cpu_busy=0, cpu_done=0, cpu_q=0; ram_we forced 0. Outstanding transaction dropped with no done.
- Write, FIFO not full: start at cycle N, done at N+1, busy high N+1 only (busy rises the cycle after start).
- Write retired to RAM: earliest N+2 (first free slot after push).
- Read, FIFO empty, no gpu_slot: start N, R_WAIT N+1, R_ISSUE N+2 (addr driven), capture/done N+3. Each gpu_slot cycle in R_ISSUE adds one cycle; each buffered write adds ≥1 cycle.
- gpu_q combinational from ram_q; PixelEngine sees data 1 cycle after gpu_addr, never displaced.

## Test plan
- Reset mid-write with fifo_level=3 → fifo_level=0, ram_we=0 immediately, no cpu_done, next write proceeds normally.
- Continuous gpu_req=1, blank=0, 4 writes → each done N+1, fifo_level reaches 4, ram_we stays 0; 5th write: no done until blank=1, first pop at blank edge, done one cycle later.
- Write 0x1234←0xAB then read 0x1234 with gpu_req busy pattern 1,0,1,0 → write retires first, read returns cpu_q=0xAB.
- gpu_req toggling 1,0 every cycle, 8 writes to 0x00000–0x00007 → all land in order in gaps, gpu_addr never overridden when gpu_req=1 (ram_we=0 every such cycle).
- Idle, read 0x1FFFF (ram holds 0x5C) → done exactly 3 cycles after start, cpu_q=0x5C.
- cpu_start during busy read → ignored; exactly one done; FIFO pointer wrap over 10 writes checked in order.
